// File: rtl/exception_redirect_ctrl_pkg.sv
// Shared types and constants for the exception/ERET redirect sequencer.
// Holds the state encoding, default parameters and the ExcCodes that carry a BadVAddr.
package exception_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;
    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned DRAIN_MAX_DEF    = 255;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // Address-error exceptions are the only ones that update BadVAddr.
    function automatic logic needs_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exception_redirect_ctrl.sv
// Exception/ERET commit sequencer: latch request, commit CP0 once, drain memory,
// flush the pipeline and issue a single PC redirect.
module exception_redirect_ctrl
    import exception_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned DRAIN_MAX    = DRAIN_MAX_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_is_ds,
    input  logic        eret_req,
    input  logic [31:0] cp0_epc,
    input  logic        stall_w,
    input  logic        mem_busy,
    output logic        busy,
    output logic        flush_all,
    output logic        stall_fetch,
    output logic        cp0_commit,
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc_wdata,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;
    logic        timeout_hit;

    logic        busy_q, busy_d;
    logic        cp0_commit_q, cp0_commit_d;
    logic        cp0_exl_set_q, cp0_exl_set_d;
    logic        cp0_exl_clr_q, cp0_exl_clr_d;
    logic [4:0]  cp0_excode_q, cp0_excode_d;
    logic        cp0_bd_q, cp0_bd_d;
    logic [31:0] cp0_epc_wdata_q, cp0_epc_wdata_d;
    logic        cp0_badvaddr_we_q, cp0_badvaddr_we_d;
    logic [31:0] cp0_badvaddr_q, cp0_badvaddr_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        drain_timeout_q, drain_timeout_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((exc_req || eret_req) && !stall_w) begin
                    accept  = 1'b1;
                    state_d = ST_DRAIN;
                    // Counter holds the number of DRAIN cycles including the current one.
                    cnt_d   = 8'd1;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = 8'd0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_REDIRECT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered copies line up
    // with the state the FSM is in during the following cycle.
    always_comb begin
        busy_d            = (state_d != ST_IDLE);
        redirect_valid_d  = (state_d == ST_REDIRECT);
        cp0_commit_d      = accept;
        cp0_exl_set_d     = accept && exc_req;
        cp0_exl_clr_d     = accept && !exc_req;
        cp0_badvaddr_we_d = accept && exc_req && needs_badvaddr(exc_code);
        cp0_excode_d      = cp0_excode_q;
        cp0_bd_d          = cp0_bd_q;
        cp0_epc_wdata_d   = cp0_epc_wdata_q;
        cp0_badvaddr_d    = cp0_badvaddr_q;
        redirect_pc_d     = redirect_pc_q;
        drain_timeout_d   = drain_timeout_q || timeout_hit;
        if (accept) begin
            if (exc_req) begin
                cp0_excode_d    = exc_code;
                cp0_bd_d        = exc_is_ds;
                cp0_epc_wdata_d = exc_epc;
                cp0_badvaddr_d  = exc_badvaddr;
                redirect_pc_d   = EXC_VECTOR;
            end else begin
                redirect_pc_d   = cp0_epc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q            <= 1'b0;
            cp0_commit_q      <= 1'b0;
            cp0_exl_set_q     <= 1'b0;
            cp0_exl_clr_q     <= 1'b0;
            cp0_excode_q      <= 5'd0;
            cp0_bd_q          <= 1'b0;
            cp0_epc_wdata_q   <= 32'd0;
            cp0_badvaddr_we_q <= 1'b0;
            cp0_badvaddr_q    <= 32'd0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= 32'd0;
            drain_timeout_q   <= 1'b0;
        end else begin
            busy_q            <= busy_d;
            cp0_commit_q      <= cp0_commit_d;
            cp0_exl_set_q     <= cp0_exl_set_d;
            cp0_exl_clr_q     <= cp0_exl_clr_d;
            cp0_excode_q      <= cp0_excode_d;
            cp0_bd_q          <= cp0_bd_d;
            cp0_epc_wdata_q   <= cp0_epc_wdata_d;
            cp0_badvaddr_we_q <= cp0_badvaddr_we_d;
            cp0_badvaddr_q    <= cp0_badvaddr_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            drain_timeout_q   <= drain_timeout_d;
        end
    end

    // Flush and fetch stall track busy exactly, so they share its flop.
    assign busy            = busy_q;
    assign flush_all       = busy_q;
    assign stall_fetch     = busy_q;
    assign cp0_commit      = cp0_commit_q;
    assign cp0_exl_set     = cp0_exl_set_q;
    assign cp0_exl_clr     = cp0_exl_clr_q;
    assign cp0_excode      = cp0_excode_q;
    assign cp0_bd          = cp0_bd_q;
    assign cp0_epc_wdata   = cp0_epc_wdata_q;
    assign cp0_badvaddr_we = cp0_badvaddr_we_q;
    assign cp0_badvaddr    = cp0_badvaddr_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign drain_timeout   = drain_timeout_q;

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// Directed self-checking bench for exception_redirect_ctrl.
// Cycle c0 is the cycle a request is presented; outputs are sampled 1ns after each edge.
module tb_exception_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_req, eret_req, exc_is_ds, stall_w, mem_busy;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc, exc_badvaddr, cp0_epc;
    logic        busy, flush_all, stall_fetch, cp0_commit, cp0_exl_set, cp0_exl_clr;
    logic [4:0]  cp0_excode;
    logic        cp0_bd, cp0_badvaddr_we, redirect_valid, drain_timeout;
    logic [31:0] cp0_epc_wdata, cp0_badvaddr, redirect_pc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base;
    int commit_cnt, redir_cnt, commit_cyc, redir_cyc;
    logic commit_set, commit_clr, commit_bvwe;
    logic [31:0] redir_pc_seen;

    always #5 clk = ~clk;

    exception_redirect_ctrl dut (
        .clk(clk), .resetn(resetn),
        .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_badvaddr(exc_badvaddr), .exc_is_ds(exc_is_ds), .eret_req(eret_req),
        .cp0_epc(cp0_epc), .stall_w(stall_w), .mem_busy(mem_busy),
        .busy(busy), .flush_all(flush_all), .stall_fetch(stall_fetch),
        .cp0_commit(cp0_commit), .cp0_exl_set(cp0_exl_set), .cp0_exl_clr(cp0_exl_clr),
        .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_epc_wdata(cp0_epc_wdata),
        .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .drain_timeout(drain_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_rec();
        commit_cnt    = 0;
        redir_cnt     = 0;
        commit_cyc    = -1;
        redir_cyc     = -1;
        commit_set    = 1'b0;
        commit_clr    = 1'b0;
        commit_bvwe   = 1'b0;
        redir_pc_seen = 32'd0;
    endtask

    // Advance one cycle and log any commit/redirect strobes seen in it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cp0_commit) begin
            commit_cnt++;
            commit_cyc  = cyc;
            commit_set  = cp0_exl_set;
            commit_clr  = cp0_exl_clr;
            commit_bvwe = cp0_badvaddr_we;
        end
        if (redirect_valid) begin
            redir_cnt++;
            redir_cyc     = cyc;
            redir_pc_seen = redirect_pc;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        resetn = 1'b0; exc_req = 1'b0; eret_req = 1'b0; exc_is_ds = 1'b0;
        stall_w = 1'b0; mem_busy = 1'b0; exc_code = 5'd0; exc_epc = 32'd0;
        exc_badvaddr = 32'd0; cp0_epc = 32'd0;
        clr_rec();
        #12 resetn = 1'b1;
        tick(); tick();
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_flush",     32'(flush_all), 32'd0);
        check("rst_commit",    32'(cp0_commit), 32'd0);
        check("rst_redirect",  32'(redirect_valid), 32'd0);
        check("rst_pc",        redirect_pc, 32'd0);
        check("rst_timeout",   32'(drain_timeout), 32'd0);

        // Plain exception, no memory traffic.
        clr_rec();
        exc_req = 1'b1; exc_code = 5'h0C; exc_epc = 32'h8000_0104;
        exc_badvaddr = 32'hDEAD_BEEF; exc_is_ds = 1'b1;
        base = cyc;
        tick();
        exc_req = 1'b0;
        check("t1_commit_c1",  32'(cp0_commit), 32'd1);
        check("t1_exl_set",    32'(cp0_exl_set), 32'd1);
        check("t1_exl_clr",    32'(cp0_exl_clr), 32'd0);
        check("t1_bv_we",      32'(cp0_badvaddr_we), 32'd0);
        check("t1_excode",     32'(cp0_excode), 32'h0C);
        check("t1_bd",         32'(cp0_bd), 32'd1);
        check("t1_epc",        cp0_epc_wdata, 32'h8000_0104);
        check("t1_busy_c1",    32'(busy), 32'd1);
        check("t1_stall_c1",   32'(stall_fetch), 32'd1);
        tick();
        check("t1_no_repulse", 32'(cp0_commit), 32'd0);
        check("t1_flush_c2",   32'(flush_all), 32'd1);
        run_to(base + 4);
        check("t1_redir_c4",   32'(redirect_valid), 32'd1);
        check("t1_redir_pc",   redirect_pc, 32'hBFC0_0380);
        check("t1_busy_c4",    32'(busy), 32'd1);
        tick();
        check("t1_idle_busy",  32'(busy), 32'd0);
        check("t1_idle_flush", 32'(flush_all), 32'd0);
        check("t1_one_redir",  32'(redir_cnt), 32'd1);

        // ERET presented in the first IDLE cycle after the previous redirect.
        clr_rec();
        eret_req = 1'b1; cp0_epc = 32'h8000_2000;
        base = cyc;
        tick();
        eret_req = 1'b0; cp0_epc = 32'h1111_1111;
        check("t2_commit_c1",  32'(cp0_commit), 32'd1);
        check("t2_exl_clr",    32'(cp0_exl_clr), 32'd1);
        check("t2_exl_set",    32'(cp0_exl_set), 32'd0);
        check("t2_bv_we",      32'(cp0_badvaddr_we), 32'd0);
        run_to(base + 6);
        check("t2_redir_cyc",  32'(redir_cyc - base), 32'd4);
        check("t2_redir_pc",   redir_pc_seen, 32'h8000_2000);

        // Address error with memory busy for 10 cycles starting at c0.
        clr_rec();
        exc_req = 1'b1; exc_code = 5'h04; exc_badvaddr = 32'h0000_0003;
        exc_epc = 32'h8000_0200; exc_is_ds = 1'b0; mem_busy = 1'b1;
        base = cyc;
        tick();
        exc_req = 1'b0;
        check("t3_bv_we",      32'(cp0_badvaddr_we), 32'd1);
        check("t3_badvaddr",   cp0_badvaddr, 32'h0000_0003);
        check("t3_bd",         32'(cp0_bd), 32'd0);
        run_to(base + 5);
        check("t3_flush_drain", 32'(flush_all), 32'd1);
        check("t3_commit_once", 32'(commit_cnt), 32'd1);
        run_to(base + 10);
        mem_busy = 1'b0;
        run_to(base + 15);
        check("t3_redir_cyc",  32'(redir_cyc - base), 32'd13);
        check("t3_redir_cnt",  32'(redir_cnt), 32'd1);

        // Simultaneous exc/eret, then a second exception during FLUSH.
        clr_rec();
        exc_req = 1'b1; eret_req = 1'b1; exc_code = 5'h0D; cp0_epc = 32'h8000_3000;
        base = cyc;
        tick();
        exc_req = 1'b0; eret_req = 1'b0;
        tick();
        exc_req = 1'b1; exc_code = 5'h05;
        tick();
        exc_req = 1'b0;
        run_to(base + 8);
        check("t4_commit_cnt", 32'(commit_cnt), 32'd1);
        check("t4_exc_wins",   32'(commit_set), 32'd1);
        check("t4_no_eret",    32'(commit_clr), 32'd0);
        check("t4_bv_we",      32'(commit_bvwe), 32'd0);
        check("t4_redir_cnt",  32'(redir_cnt), 32'd1);
        check("t4_redir_cyc",  32'(redir_cyc - base), 32'd4);
        check("t4_redir_pc",   redir_pc_seen, 32'hBFC0_0380);
        check("t4_excode",     32'(cp0_excode), 32'h0D);

        // Memory stuck busy: forced exit after 255 DRAIN cycles.
        clr_rec();
        exc_req = 1'b1; exc_code = 5'h0C; mem_busy = 1'b1;
        base = cyc;
        tick();
        exc_req = 1'b0;
        run_to(base + 255);
        check("t5_to_c255",    32'(drain_timeout), 32'd0);
        check("t5_busy_c255",  32'(busy), 32'd1);
        check("t5_no_redir",   32'(redir_cnt), 32'd0);
        tick();
        check("t5_to_c256",    32'(drain_timeout), 32'd1);
        run_to(base + 260);
        mem_busy = 1'b0;
        check("t5_redir_cyc",  32'(redir_cyc - base), 32'd258);
        run_to(base + 264);
        check("t5_sticky",     32'(drain_timeout), 32'd1);

        // Async reset in FLUSH: outputs clear immediately and no redirect follows.
        clr_rec();
        exc_req = 1'b1; exc_code = 5'h0C;
        tick();
        exc_req = 1'b0;
        tick();
        check("t6_in_flush",   32'(flush_all), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_busy",   32'(busy), 32'd0);
        check("t6_rst_stall",  32'(stall_fetch), 32'd0);
        check("t6_rst_pc",     redirect_pc, 32'd0);
        check("t6_rst_to",     32'(drain_timeout), 32'd0);
        tick();
        resetn = 1'b1;
        clr_rec();
        base = cyc;
        run_to(base + 6);
        check("t6_no_redir",   32'(redir_cnt), 32'd0);
        check("t6_no_commit",  32'(commit_cnt), 32'd0);

        // stall_w blocks acceptance until it drops.
        clr_rec();
        stall_w = 1'b1; exc_req = 1'b1; exc_code = 5'h0C;
        base = cyc;
        run_to(base + 4);
        check("t7_stall_busy", 32'(busy), 32'd0);
        check("t7_stall_cmt",  32'(commit_cnt), 32'd0);
        stall_w = 1'b0;
        tick();
        exc_req = 1'b0;
        check("t7_accept",     32'(cp0_commit), 32'd1);
        run_to(cyc + 6);
        check("t7_redir_cnt",  32'(redir_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
